fetch_unit: RTL and testbench

Instruction fetch stage for the simple CPU. Owns the program counter, drives the address of the synchronous 1-cycle-latency instruction ROM, and captures the returned words into a 2-entry buffer. Presents instructions with their PC to decode over a valid/ready handshake. Accepts jump redirects from execute, which flush all fetched-but-unconsumed words.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo2.sv | 95 +++++++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage, ROM and decode.
// Holds the bus width defaults, the reset PC and the fetch buffer depth.
package fetch_unit_pkg;

    localparam int CPU_ADDR_WIDTH = 8;
    localparam int CPU_DATA_WIDTH = 32;
    localparam logic [CPU_ADDR_WIDTH-1:0] CPU_RESET_PC = '0;

    localparam int FIFO_DEPTH = 2;
    typedef logic [1:0] fifo_count_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, jump redirect from execute, and the decode handshake.
// The master modport is the fetch unit; the slave modport is everything around it.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = fetch_unit_pkg::CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = fetch_unit_pkg::CPU_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  jump_valid;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output rom_addr, inst_valid, inst_data, inst_pc,
        input  rom_data, jump_valid, jump_addr, inst_ready
    );

    modport slave (
        input  rom_addr, inst_valid, inst_data, inst_pc,
        output rom_data, jump_valid, jump_addr, inst_ready
    );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, data} buffer with a registered head, same-edge push/pop and flush.
// The head register feeds decode directly, so its outputs have no input paths.
module fetch_fifo2
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = CPU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_data,
    output fifo_count_t           count
);

    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    fifo_count_t           count_q, count_d;
    logic                  pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        tail_pc_d   = tail_pc_q;
        tail_data_d = tail_data_q;
        count_d     = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop_ok})
                2'b11: begin
                    if (count_q == fifo_count_t'(FIFO_DEPTH)) begin
                        head_pc_d   = tail_pc_q;
                        head_data_d = tail_data_q;
                        tail_pc_d   = push_pc;
                        tail_data_d = push_data;
                    end else begin
                        head_pc_d   = push_pc;
                        head_data_d = push_data;
                    end
                end
                2'b01: begin
                    head_pc_d   = tail_pc_q;
                    head_data_d = tail_data_q;
                    count_d     = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == '0) begin
                        head_pc_d   = push_pc;
                        head_data_d = push_data;
                    end else begin
                        tail_pc_d   = push_pc;
                        tail_data_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q     <= '0;
            head_pc_q   <= '0;
            head_data_q <= '0;
        end else begin
            count_q     <= count_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
        end
    end

    // NOTE: the tail is storage only and is never observed while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        tail_pc_q   <= tail_pc_d;
        tail_data_q <= tail_data_d;
    end

    assign head_valid = (count_q != '0);
    assign head_pc    = head_pc_q;
    assign head_data  = head_data_q;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the 1-cycle ROM, buffers returned words
// for decode, and flushes everything fetched-but-unconsumed on a jump redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = CPU_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  pop, issue, push;
    logic [2:0]            occupancy;
    fifo_count_t           fifo_count;
    logic                  head_valid;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_data;

    assign pop  = head_valid && bus.inst_ready;
    assign push = inflight_q && !bus.jump_valid;

    // Issue only when every buffered or in-flight word still has a slot after this pop.
    always_comb begin
        occupancy     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = !bus.jump_valid && (occupancy < 3'(FIFO_DEPTH));
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (bus.jump_valid) begin
            pc_d = bus.jump_addr;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_WIDTH'(1);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo2 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (bus.jump_valid),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_data  (bus.rom_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign bus.rom_addr   = pc_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst_pc    = head_pc;
    assign bus.inst_data  = head_data;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, a throughput sequence,
// and a randomized ready/jump/reset run against a program-order scoreboard.
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [AW-1:0] RST_PC = 8'h00;
    localparam logic [DW-1:0] ROM_TAG = 32'hA500_0000;

    logic clk = 1'b0;
    logic reset_n;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ROM model: the word for the address sampled at an edge appears after that edge.
    always @(posedge clk) bus.rom_data <= ROM_TAG | 32'(bus.rom_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic          rst_n;
        logic          ready;
        logic          jv;
        logic [AW-1:0] ja;
        logic          ev;
        logic          chk;
        logic [AW-1:0] epc;
        logic [AW-1:0] erom;
        logic [1:0]    ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst_n, input logic ready, input logic jv,
                               input logic [AW-1:0] ja, input logic ev, input logic chk,
                               input logic [AW-1:0] epc, input logic [AW-1:0] erom,
                               input logic [1:0] ecnt);
        vec_t r;
        r.rst_n = rst_n; r.ready = ready; r.jv = jv; r.ja = ja;
        r.ev = ev; r.chk = chk; r.epc = epc; r.erom = erom; r.ecnt = ecnt;
        return r;
    endfunction

    logic          r_rst, r_jv, r_rdy;
    logic [AW-1:0] r_ja, exp_pc, tgt;
    int            since;

    initial begin
        reset_n        = 1'b0;
        bus.inst_ready = 1'b0;
        bus.jump_valid = 1'b0;
        bus.jump_addr  = '0;

        // Reset, then release with ready high (E0 = third row)
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 2'd0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h02, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h03, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h02, 8'h04, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2'd1));
        // Backpressure for 6 cycles: head, rom_addr frozen, buffer full
        for (int i = 0; i < 6; i++)
            vecs.push_back(v(1, 0, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2'd2));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h04, 8'h06, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h05, 8'h07, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h06, 8'h08, 2'd1));
        // Fill, then jump to 40 while full with a pop in the jump cycle
        vecs.push_back(v(1, 0, 0, 8'h00, 1, 1, 8'h06, 8'h08, 2'd2));
        vecs.push_back(v(1, 1, 1, 8'h40, 0, 0, 8'h00, 8'h40, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h41, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h40, 8'h42, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h41, 8'h43, 2'd1));
        // Jump to FE and wrap through 00
        vecs.push_back(v(1, 1, 1, 8'hFE, 0, 0, 8'h00, 8'hFE, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'hFE, 8'h00, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'hFF, 8'h01, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h02, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h03, 2'd1));
        // One-edge reset mid-stream, then identical E0/E1 timing
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 2'd0));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h00, 8'h02, 2'd1));
        vecs.push_back(v(1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h03, 2'd1));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n        = vecs[i].rst_n;
            bus.inst_ready = vecs[i].ready;
            bus.jump_valid = vecs[i].jv;
            bus.jump_addr  = vecs[i].ja;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(bus.inst_valid), 32'(vecs[i].ev));
            check($sformatf("tbl%0d_rom_addr", i), 32'(bus.rom_addr), 32'(vecs[i].erom));
            check($sformatf("tbl%0d_count", i), 32'(dut.fifo_count), 32'(vecs[i].ecnt));
            if (vecs[i].chk) begin
                check($sformatf("tbl%0d_pc", i), 32'(bus.inst_pc), 32'(vecs[i].epc));
                check($sformatf("tbl%0d_data", i), bus.inst_data,
                      vecs[i].ev ? (ROM_TAG | 32'(vecs[i].epc)) : 32'h0);
            end
        end

        // Throughput: ready held high gives one word per cycle at consecutive PCs
        @(negedge clk);
        reset_n        = 1'b0;
        bus.jump_valid = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("thru_valid", 32'(bus.inst_valid), 32'd1);
            check("thru_pc", 32'(bus.inst_pc), 32'(k));
        end

        // Randomized ready, jumps and rare resets against a program-order scoreboard
        since  = 3;
        exp_pc = RST_PC;
        tgt    = RST_PC;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            r_rst = (c == 0) || ($urandom_range(0, 499) == 0);
            r_jv  = ($urandom_range(0, 99) < 6);
            r_ja  = ($urandom_range(0, 3) == 0) ? AW'(8'hFC + $urandom_range(0, 3)) : AW'($urandom);
            r_rdy = ($urandom_range(0, 99) < 65);
            reset_n        = !r_rst;
            bus.jump_valid = r_jv;
            bus.jump_addr  = r_ja;
            bus.inst_ready = r_rdy;
            if (c != 0 && bus.inst_valid && bus.inst_ready) begin
                check("rnd_pc", 32'(bus.inst_pc), 32'(exp_pc));
                check("rnd_data", bus.inst_data, ROM_TAG | 32'(exp_pc));
                exp_pc = exp_pc + 8'd1;
            end
            if (r_rst) begin
                exp_pc = RST_PC;
                tgt    = RST_PC;
                since  = 0;
            end else if (r_jv) begin
                exp_pc = r_ja;
                tgt    = r_ja;
                since  = 0;
            end else if (since < 3) begin
                since++;
            end
            @(posedge clk);
            #1;
            if (since == 0) begin
                check("rnd_flush_valid", 32'(bus.inst_valid), 32'd0);
                check("rnd_flush_rom", 32'(bus.rom_addr), 32'(tgt));
            end else if (since == 1) begin
                check("rnd_bubble_valid", 32'(bus.inst_valid), 32'd0);
            end else if (since == 2) begin
                check("rnd_target_valid", 32'(bus.inst_valid), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
